// File: rtl/team_06_audio_pkg.sv
// Shared widths, constants and types for the team_06 audio output path.
package team_06_audio_pkg;

  localparam int AUDIO_W    = 8;
  localparam int VOL_W      = 4;
  localparam int GAIN_SHIFT = 4;

  // Offset-removed sample carries one extra bit so -128..127 is representable.
  localparam int DIFF_W = AUDIO_W + 1;
  // Gain reaches 16 (volume 15 + 1), so it needs one bit more than the code.
  localparam int GAIN_W = VOL_W + 1;
  localparam int PROD_W = DIFF_W + GAIN_W;

  localparam logic [AUDIO_W-1:0] MIDSCALE = 8'h80;

  typedef logic [AUDIO_W-1:0] sample_t;
  typedef logic [VOL_W-1:0]   vol_t;

endpackage

// File: rtl/team_06_gain_mult.sv
// Combinational shift-and-add multiplier: signed sample times unsigned gain.
module team_06_gain_mult
  import team_06_audio_pkg::*;
(
  input  logic signed [DIFF_W-1:0] d,
  input  logic        [GAIN_W-1:0] g,
  output logic signed [PROD_W-1:0] p
);

  logic signed [PROD_W-1:0] d_ext;

  assign d_ext = {{(PROD_W-DIFF_W){d[DIFF_W-1]}}, d};

  // Accumulate d shifted by k for every set bit k of the gain.
  always_comb begin
    p = '0;
    for (int k = 0; k < GAIN_W; k++) begin
      if (g[k]) begin
        p = p + (d_ext <<< k);
      end
    end
  end

endmodule

// File: rtl/team_06_volume_shifter.sv
// Volume control stage: scales offset-binary PCM by a 4-bit volume code,
// or passes it through untouched in bypass. One registered clock of latency.
module team_06_volume_shifter
  import team_06_audio_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [AUDIO_W-1:0] audio_in,
  input  logic [VOL_W-1:0]   volume,
  input  logic               enable_volume,
  output logic [AUDIO_W-1:0] audio_out
);

  logic signed [DIFF_W-1:0] d;
  logic        [GAIN_W-1:0] g;
  logic signed [PROD_W-1:0] p;
  logic signed [PROD_W-1:0] p_shift;
  logic        [AUDIO_W-1:0] scaled;

  // Remove the midscale bias so silence sits at zero.
  assign d = $signed({1'b0, audio_in}) - $signed({1'b0, MIDSCALE});

  // Code 0 mutes; otherwise gain = code + 1, so code 15 gives 16/16 = unity.
  assign g = (volume == '0) ? '0 : ({1'b0, volume} + GAIN_W'(1));

  team_06_gain_mult u_gain_mult (
    .d (d),
    .g (g),
    .p (p)
  );

  // Divide by 16 with floor rounding; the gain never exceeds 16 so the
  // result always lands back in -128..127 and needs no saturation.
  assign p_shift = p >>> GAIN_SHIFT;

  // Re-apply the bias: adding 0x80 to an 8-bit two's complement value.
  assign scaled = p_shift[AUDIO_W-1:0] + MIDSCALE;

  // Output register: reset to silence, otherwise scaled or bypassed sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      audio_out <= MIDSCALE;
    end else if (enable_volume) begin
      audio_out <= scaled;
    end else begin
      audio_out <= audio_in;
    end
  end

  shift_in_range : assert property (@(posedge clk) disable iff (rst)
    enable_volume |-> (p_shift >= -14'sd128 && p_shift <= 14'sd127));

endmodule

// File: tb/tb_team_06_volume_shifter.sv
// Self-checking bench for team_06_volume_shifter with a scoreboard queue.
module tb_team_06_volume_shifter;

  logic       clk;
  logic       rst;
  logic [7:0] audio_in;
  logic [3:0] volume;
  logic       enable_volume;
  logic [7:0] audio_out;

  logic [7:0] exp_q[$];
  int         vectors;
  int         miscompares;

  team_06_volume_shifter dut (
    .clk           (clk),
    .rst           (rst),
    .audio_in      (audio_in),
    .volume        (volume),
    .enable_volume (enable_volume),
    .audio_out     (audio_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model written straight from the scaling formulas.
  function automatic logic [7:0] model(input logic [7:0] in, input logic [3:0] vol,
                                       input logic en);
    int dd, gg, pp, ss;
    if (!en) return in;
    dd = int'(in) - 128;
    gg = (vol == 4'd0) ? 0 : int'(vol) + 1;
    pp = dd * gg;
    ss = pp >>> 4;
    return 8'(ss + 128);
  endfunction

  // Drive one input set at the falling edge, record its expected output,
  // then move to just after the rising edge where that output appears.
  task automatic apply_vector(input logic r, input logic [7:0] in, input logic [3:0] vol,
                              input logic en, input logic [7:0] expv);
    @(negedge clk);
    rst = r;
    audio_in = in;
    volume = vol;
    enable_volume = en;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] expv;
    apply_vector(1'b1, 8'h33, 4'd6, 1'b1, 8'h80);
    expv = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    vectors++;
    if (audio_out !== expv) begin
      miscompares++;
      $display("[TB] FAIL reset got %02h expected %02h", audio_out, expv);
    end
    apply_vector(1'b1, 8'hF0, 4'd2, 1'b0, 8'h80);
    expv = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    vectors++;
    if (audio_out !== expv) begin
      miscompares++;
      $display("[TB] FAIL reset_bypass got %02h expected %02h", audio_out, expv);
    end
  endtask

  task automatic test_bypass();
    logic [7:0] ins [3] = '{8'd64, 8'h13, 8'hFF};
    logic [3:0] vols[3] = '{4'd6, 4'd0, 4'd3};
    logic [7:0] expv;
    for (int i = 0; i < 3; i++) begin
      apply_vector(1'b0, ins[i], vols[i], 1'b0, ins[i]);
      expv = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      vectors++;
      if (audio_out !== expv) begin
        miscompares++;
        $display("[TB] FAIL bypass[%0d] got %02h expected %02h", i, audio_out, expv);
      end
    end
  endtask

  task automatic test_scaling();
    logic [7:0] ins [8] = '{8'd64, 8'd255, 8'd0, 8'd0, 8'd255, 8'h80, 8'hC0, 8'h7F};
    logic [3:0] vols[8] = '{4'd6, 4'd15, 4'd8, 4'd15, 4'd0, 4'd7, 4'd3, 4'd1};
    logic [7:0] exps[8] = '{8'd100, 8'd255, 8'd56, 8'd0, 8'd128, 8'h80, 8'h90, 8'h7F};
    logic [7:0] expv;
    for (int i = 0; i < 8; i++) begin
      apply_vector(1'b0, ins[i], vols[i], 1'b1, exps[i]);
      expv = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      vectors++;
      if (audio_out !== expv) begin
        miscompares++;
        $display("[TB] FAIL scaling[%0d] got %02h expected %02h", i, audio_out, expv);
      end
    end
  endtask

  task automatic test_toggle_latency();
    logic       ens[3] = '{1'b1, 1'b0, 1'b1};
    logic [7:0] expv;
    for (int i = 0; i < 3; i++) begin
      apply_vector(1'b0, 8'd255, 4'd15, ens[i], 8'd255);
      expv = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      vectors++;
      if (audio_out !== expv) begin
        miscompares++;
        $display("[TB] FAIL toggle[%0d] got %02h expected %02h", i, audio_out, expv);
      end
    end
    // New input applied; output must hold the old value until the next edge.
    @(negedge clk);
    audio_in = 8'h00;
    enable_volume = 1'b0;
    #1;
    vectors++;
    if (audio_out !== 8'd255) begin
      miscompares++;
      $display("[TB] FAIL latency_hold got %02h expected ff", audio_out);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (audio_out !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL latency_update got %02h expected 00", audio_out);
    end
  endtask

  task automatic test_midstream_reset();
    logic       rsts[3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] exps[3] = '{8'd56, 8'h80, 8'd56};
    logic [7:0] expv;
    for (int i = 0; i < 3; i++) begin
      apply_vector(rsts[i], 8'd0, 4'd8, 1'b1, exps[i]);
      expv = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      vectors++;
      if (audio_out !== expv) begin
        miscompares++;
        $display("[TB] FAIL midreset[%0d] got %02h expected %02h", i, audio_out, expv);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] in;
    logic [3:0] vol;
    logic       en;
    logic [7:0] expv;
    for (int i = 0; i < 10000; i++) begin
      in  = 8'($urandom);
      vol = 4'($urandom);
      en  = 1'($urandom);
      apply_vector(1'b0, in, vol, en, model(in, vol, en));
      expv = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      vectors++;
      if (audio_out !== expv) begin
        miscompares++;
        $display("[TB] FAIL random[%0d] in=%02h vol=%0d en=%0b got %02h expected %02h",
                 i, in, vol, en, audio_out, expv);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    audio_in = 8'h00;
    volume = 4'd0;
    enable_volume = 1'b0;
    $display("[TB] starting team_06_volume_shifter bench");
    test_reset();
    test_bypass();
    test_scaling();
    test_toggle_latency();
    test_midstream_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
